// File: rtl/hexa7seg_pkg.sv
// Shared types and 7-segment encoding for the N-player turn display.
// Segments are active-low in gfedcba order.
package hexa7seg_pkg;

  typedef enum logic [1:0] {DESLIGADO, MOSTRA, PISCA, VITORIA} estado_t;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;

  // idx is the 0-based player index; the display shows idx+1.
  function automatic logic [6:0] digito7seg(input logic [3:0] idx, input int n);
    logic [6:0] seg;
    if (int'(idx) >= n) begin
      seg = SEG_TRACO;
    end else begin
      case (idx)
        4'd0:    seg = 7'b1111001;
        4'd1:    seg = 7'b0100100;
        4'd2:    seg = 7'b0110000;
        4'd3:    seg = 7'b0011001;
        4'd4:    seg = 7'b0010010;
        4'd5:    seg = 7'b0000010;
        4'd6:    seg = 7'b1111000;
        4'd7:    seg = 7'b0000000;
        4'd8:    seg = 7'b0010000;
        default: seg = SEG_TRACO;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/hexa7seg_jogador_n_pisca_timer.sv
// Blink timer: DIV_PISCA cycles per phase; fase_o is the phase after the next edge.
// The period counter and fim_o exist only with HEXA7SEG_TROCA_PISCA_EN defined.
module pisca_timer #(
  parameter int DIV_PISCA  = 25000000,
  parameter int N_PISCADAS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  output logic fase_o
`ifdef HEXA7SEG_TROCA_PISCA_EN
  ,
  output logic fim_o
`endif
);

  localparam int CW = $clog2(DIV_PISCA + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(DIV_PISCA - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fase_q, fase_d;
  logic          vira;

  assign vira = (cnt_q == CNT_FIM);

  // Counters clear whenever the timer is not running, so every entry starts fresh.
  always_comb begin
    cnt_d  = '0;
    fase_d = 1'b0;
    if (!start_i && run_i) begin
      if (vira) begin
        cnt_d  = '0;
        fase_d = ~fase_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        fase_d = fase_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      fase_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fase_q <= fase_d;
    end
  end

  assign fase_o = fase_d;

`ifdef HEXA7SEG_TROCA_PISCA_EN
  localparam int PW = $clog2(N_PISCADAS + 1);
  localparam logic [PW-1:0] PER_FIM = PW'(N_PISCADAS);
  localparam logic [PW-1:0] PER_ULT = PW'(N_PISCADAS - 1);

  logic [PW-1:0] per_q, per_d;

  always_comb begin
    per_d = '0;
    if (!start_i && run_i) begin
      per_d = per_q;
      if (vira && fase_q && (per_q != PER_FIM)) per_d = per_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) per_q <= '0;
    else        per_q <= per_d;
  end

  // High in the cycle whose closing edge completes the last on phase.
  assign fim_o = vira && fase_q && (per_q == PER_ULT);
`endif

endmodule

// File: rtl/hexa7seg_jogador_n.sv
// Registered 7-segment turn indicator for N players with turn-change and victory blinking.
// Turn-change blinking (PISCA state) is built only with HEXA7SEG_TROCA_PISCA_EN defined.
module hexa7seg_jogador_n
  import hexa7seg_pkg::*;
#(
  parameter int N_JOGADORES = 2,
  parameter int DIV_PISCA   = 25000000,
  parameter int N_PISCADAS  = 3,
  localparam int W = (N_JOGADORES > 2) ? $clog2(N_JOGADORES) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         habilita,
  input  logic [W-1:0] jogador,
  input  logic         vencedor,
  output logic [6:0]   display,
  output logic         piscando
);

  estado_t      state_q, state_d;
  logic [W-1:0] jogador_q, jogador_d;
  logic [6:0]   display_q, display_d;
  logic         piscando_q, piscando_d;
  logic         carrega, start, run, fase, troca;
  logic [6:0]   digito;

`ifdef HEXA7SEG_TROCA_PISCA_EN
  logic fim;
`endif

  pisca_timer #(
    .DIV_PISCA (DIV_PISCA),
    .N_PISCADAS(N_PISCADAS)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .start_i(start),
    .run_i  (run),
    .fase_o (fase)
`ifdef HEXA7SEG_TROCA_PISCA_EN
    ,
    .fim_o  (fim)
`endif
  );

  assign troca = (jogador != jogador_q);

  always_comb begin
    state_d = state_q;
    carrega = 1'b0;
    start   = 1'b0;
    run     = 1'b0;
    if (!habilita) begin
      state_d = DESLIGADO;
    end else begin
      case (state_q)
        DESLIGADO: begin
          carrega = 1'b1;
          start   = 1'b1;
          state_d = vencedor ? VITORIA : MOSTRA;
        end
        MOSTRA: begin
          if (vencedor) begin
            state_d = VITORIA;
            carrega = 1'b1;
            start   = 1'b1;
          end else if (troca) begin
            carrega = 1'b1;
`ifdef HEXA7SEG_TROCA_PISCA_EN
            state_d = PISCA;
            start   = 1'b1;
`endif
          end
        end
`ifdef HEXA7SEG_TROCA_PISCA_EN
        PISCA: begin
          if (vencedor) begin
            state_d = VITORIA;
            carrega = 1'b1;
            start   = 1'b1;
          end else if (troca) begin
            carrega = 1'b1;
            start   = 1'b1;
          end else if (fim) begin
            state_d = MOSTRA;
          end else begin
            run = 1'b1;
          end
        end
`endif
        VITORIA: begin
          // The winner's index stays frozen until vencedor drops.
          if (!vencedor) begin
            state_d = MOSTRA;
            carrega = 1'b1;
          end else begin
            run = 1'b1;
          end
        end
        default: state_d = DESLIGADO;
      endcase
    end
  end

  // Output decode works on next-state values so the display lags its inputs by one edge only.
  always_comb begin
    jogador_d  = carrega ? jogador : jogador_q;
    digito     = digito7seg(4'(jogador_d), N_JOGADORES);
    display_d  = SEG_APAGADO;
    piscando_d = 1'b0;
    case (state_d)
      MOSTRA: display_d = digito;
      PISCA, VITORIA: begin
        display_d  = fase ? digito : SEG_APAGADO;
        piscando_d = 1'b1;
      end
      default: display_d = SEG_APAGADO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= DESLIGADO;
      jogador_q  <= '0;
      display_q  <= SEG_APAGADO;
      piscando_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      jogador_q  <= jogador_d;
      display_q  <= display_d;
      piscando_q <= piscando_d;
    end
  end

  assign display  = display_q;
  assign piscando = piscando_q;

endmodule

// File: tb/tb_hexa7seg_jogador_n.sv
// Scoreboard bench for hexa7seg_jogador_n (3 players, 4-cycle phases, 2 blinks).
// The reference model tracks elapsed cycles since a blink started and derives the phase arithmetically.
module tb_hexa7seg_jogador_n;

  localparam int NJ  = 3;
  localparam int DIV = 4;
  localparam int NP  = 2;
  localparam int W   = 2;

`ifdef HEXA7SEG_TROCA_PISCA_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam int M_OFF = 0, M_SHOW = 1, M_BLINK = 2, M_WIN = 3;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         habilita = 1'b0;
  logic         vencedor = 1'b0;
  logic [W-1:0] jogador  = '0;
  logic [6:0]   display;
  logic         piscando;

  hexa7seg_jogador_n #(
    .N_JOGADORES(NJ),
    .DIV_PISCA  (DIV),
    .N_PISCADAS (NP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .habilita(habilita),
    .jogador (jogador),
    .vencedor(vencedor),
    .display (display),
    .piscando(piscando)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] seg;
    logic       pisc;
  } saida_t;

  saida_t fila[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] tabela [0:8] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int m_modo = M_OFF;
  int m_jog  = 0;
  int m_t    = 0;

  function automatic logic [6:0] seg_de(input int idx);
    if (idx >= NJ) return 7'b0111111;
    return tabela[idx];
  endfunction

  function automatic saida_t modelo_saida();
    saida_t s;
    s.seg  = 7'b1111111;
    s.pisc = 1'b0;
    if (m_modo == M_SHOW) begin
      s.seg = seg_de(m_jog);
    end else if (m_modo == M_BLINK || m_modo == M_WIN) begin
      s.pisc = 1'b1;
      s.seg  = (((m_t / DIV) % 2) == 1) ? seg_de(m_jog) : 7'b1111111;
    end
    return s;
  endfunction

  task automatic modelo_passo(input logic h, input logic v, input int j);
    if (!h) begin
      m_modo = M_OFF;
    end else if (m_modo == M_OFF) begin
      m_jog  = j;
      m_t    = 0;
      m_modo = v ? M_WIN : M_SHOW;
    end else if (m_modo == M_SHOW) begin
      if (v) begin
        m_modo = M_WIN; m_jog = j; m_t = 0;
      end else if (j != m_jog) begin
        m_jog = j;
        if (BLINK_EN) begin
          m_modo = M_BLINK; m_t = 0;
        end
      end
    end else if (m_modo == M_BLINK) begin
      if (v) begin
        m_modo = M_WIN; m_jog = j; m_t = 0;
      end else if (j != m_jog) begin
        m_jog = j; m_t = 0;
      end else begin
        m_t++;
        if (m_t == 2 * NP * DIV) m_modo = M_SHOW;
      end
    end else begin
      if (!v) begin
        m_modo = M_SHOW; m_jog = j;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic ciclo(input logic h, input logic v, input int j);
    @(negedge clock);
    habilita = h;
    vencedor = v;
    jogador  = W'(j);
    modelo_passo(h, v, j);
    fila.push_back(modelo_saida());
  endtask

  task automatic ciclos(input int n, input logic h, input logic v, input int j);
    for (int i = 0; i < n; i++) ciclo(h, v, j);
  endtask

  task automatic checa_reset(input string nome);
    checks++;
    if (display !== 7'b1111111 || piscando !== 1'b0) begin
      errors++;
      $display("FAIL %s: display=%b piscando=%b, required display=1111111 piscando=0",
               nome, display, piscando);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        saida_t e;
        e = fila.pop_front();
        checks++;
        if (display !== e.seg || piscando !== e.pisc) begin
          errors++;
          $display("FAIL saida t=%0t: display=%b piscando=%b, required display=%b piscando=%b",
                   $time, display, piscando, e.seg, e.pisc);
        end
      end
    end
  end

  initial begin
    logic h, v;
    int   j;

    #2 reset = 1'b0;
    #1 checa_reset("reset_inicial");
    @(negedge clock);
    reset = 1'b1;
    ciclos(2, 1'b0, 1'b0, 0);

    ciclos(3, 1'b1, 1'b0, 0);
    ciclos(22, 1'b1, 1'b0, 2);
    ciclos(6, 1'b1, 1'b0, 1);
    ciclos(14, 1'b1, 1'b1, 1);
    for (int i = 0; i < 12; i++) ciclo(1'b1, 1'b1, i % 3);
    ciclos(4, 1'b1, 1'b0, 2);
    ciclos(22, 1'b1, 1'b0, 3);
    ciclos(7, 1'b1, 1'b1, 0);
    ciclos(2, 1'b0, 1'b1, 0);
    ciclos(12, 1'b1, 1'b1, 1);
    ciclos(3, 1'b1, 1'b0, 1);

    ciclos(6, 1'b1, 1'b0, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    habilita = 1'b0;
    m_modo = M_OFF; m_jog = 0; m_t = 0;
    #1 checa_reset("reset_assincrono");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    ciclos(3, 1'b0, 1'b0, 2);

    h = 1'b1; v = 1'b0; j = 0;
    for (int i = 0; i < 700; i++) begin
      h = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 3) v = ~v;
      if ($urandom_range(0, 99) < 5) j = $urandom_range(0, 3);
      ciclo(h, v, j);
    end

    @(posedge clock);
    #3;
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL fila_vazia: %0d pending, required 0", fila.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hexa7seg_jogador_n.md
Name: hexa7seg_jogador_n

Overview:
- Registered 7-segment driver for a turn indicator with N players. Shows the current player as digit 1..N.
- Blinks the digit for a fixed number of periods after every turn change. Flashes the winner continuously once the game is won.
- Sits between the game FSM (jogador, vencedor, habilita) and one board display. It is the parametrised successor of the 2-player combinational turn decoder.

Parameters:
- N_JOGADORES, 2, number of players; legal range 2..9.
- DIV_PISCA, 25000000, clock cycles per blink half-period (on or off phase); must be >= 1.
- N_PISCADAS, 3, number of full off/on blink periods after a turn change; must be >= 1.
- Derived: W = max(1, clog2(N_JOGADORES)), width of the player index.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- habilita  input  1  1 = display active; 0 = blank.
- jogador  input  W  0-based index of the player whose turn it is.
- vencedor  input  1  level; 1 = game won by the player on jogador.
- display  output  7  segments gfedcba, active-low, registered.
- piscando  output  1  1 while in PISCA or VITORIA, registered.

Behaviour:
- Reset (reset=0, asynchronous): display=7'b1111111 (blank), piscando=0, state=DESLIGADO, counters=0, jogador_reg=0.
- Digit encoding (active-low gfedcba): 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Index >= N_JOGADORES shows dash 0111111. Blank is 1111111.
- Latency: one cycle. Inputs sampled at edge k appear on display after edge k.
- States:
  - DESLIGADO: display blank. Exits when habilita=1: go to VITORIA if vencedor=1, else MOSTRA. Load jogador_reg.
  - MOSTRA: display steady digit(jogador_reg).
    - If vencedor=1, go to VITORIA.
    - Else if jogador != jogador_reg, load jogador_reg, go to PISCA, clear the counters, phase=off.
  - PISCA: the phase counter counts DIV_PISCA cycles per phase. Off phase shows blank; on phase shows the digit.
    - After N_PISCADAS complete off+on pairs (2*N_PISCADAS*DIV_PISCA cycles), go to MOSTRA.
    - A new jogador change restarts PISCA: load, clear counters, phase=off.
    - vencedor=1 overrides and goes to VITORIA.
  - VITORIA: same phase timing as PISCA with no end. Displays the jogador_reg digit.
    - jogador changes are ignored, and jogador_reg stays frozen.
    - When vencedor falls to 0, go to MOSTRA and load the current jogador. No blink.
- habilita=0 in any state: go to DESLIGADO on the next edge (priority over all else) and clear the counters.
- Simultaneous events: priority is habilita=0 > vencedor=1 > jogador change > counter expiry.
- Counters: phase counter width clog2(DIV_PISCA+1); period counter width clog2(N_PISCADAS+1). Neither wraps past its terminal value.
- piscando=1 exactly in PISCA and VITORIA.

Optional Feature:
- Macro HEXA7SEG_TROCA_PISCA_EN.
- Defined: turn-change blinking in PISCA as above.
- Undefined: the PISCA state is not built. A jogador change in MOSTRA only updates jogador_reg, and the display changes one cycle later with piscando=0. VITORIA flashing is unaffected.

Decomposition:
- Shared package hexa7seg_pkg:
  - state enum {DESLIGADO, MOSTRA, PISCA, VITORIA};
  - constants SEG_APAGADO=7'b1111111 and SEG_TRACO=7'b0111111;
  - function digito7seg(index, n) implementing the encoding table.
- One sub-module, pisca_timer: phase counter plus period counter, with inputs start and run, and outputs fase and fim.

Test Plan (N_JOGADORES=3, DIV_PISCA=4, N_PISCADAS=2):
- Reset low mid-blink -> display=1111111 and piscando=0 immediately (asynchronous), and they remain so after release while habilita=0.
- habilita=1, jogador=0 -> display=1111001 one cycle later, piscando=0.
- jogador 0->2 -> 4 cycles blank, 4 cycles 0110000, repeated twice (16 cycles), then steady 0110000 and piscando=0. With the macro undefined: 0110000 after 1 cycle, no blank.
- vencedor=1 with jogador=1 during PISCA -> 4 blank / 4 0100100 indefinitely. Toggling jogador has no effect. vencedor=0 -> steady digit of the current jogador.
- jogador=3 (out of range) -> blink sequence showing 0111111 in the on phases, then steady 0111111.
- habilita=0 during VITORIA -> blank next cycle, piscando=0; habilita=1 again with vencedor=1 -> VITORIA restarts with the off phase.
